// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the debug-link UART receiver and transmitter.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : data bits per frame (LSB first)
//   STOP_BITS  : stop bits per frame
package uart_pkg;

    typedef enum logic [1:0] {
        st_idle,
        st_start,
        st_data,
        st_stop
    } rx_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_baudgen.sv
// uart_baudgen: free-running baud tick generator.
//   CLK_I  : system clock, rising edge
//   RST_NI : asynchronous active-low reset
//   TICK_O : one-cycle pulse every BDDIVIDER clock cycles
module uart_baudgen #(
    parameter int unsigned BDDIVIDER = 27
) (
    input  logic CLK_I,
    input  logic RST_NI,
    output logic TICK_O
);

    localparam int unsigned CW = (BDDIVIDER > 1) ? $clog2(BDDIVIDER) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap   = (div_cnt == CW'(BDDIVIDER - 1));
    assign TICK_O = wrap;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            div_cnt <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: receive half of the debug-link UART (8N1, LSB first).
//   CLK_I     : system clock, rising edge
//   RST_NI    : asynchronous active-low reset
//   RX_I      : serial line, asynchronous, idle high
//   RX_DONE_O : one-cycle pulse, valid byte on RX_DATA_O
//   RX_DATA_O : last correctly received byte, held until the next valid frame
//   RX_ERR_O  : one-cycle pulse, stop bit sampled low
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned BDDIVIDER    = 27
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       RX_I,
    output logic       RX_DONE_O,
    output logic [7:0] RX_DATA_O,
    output logic       RX_ERR_O
);

    localparam int unsigned BW = $clog2(OVERSAMPLING);

    logic            baudtick;
    logic            rx_meta, rx_s, rx_q;
    rx_state_t       state_q, state_d;
    logic [BW-1:0]   btick_cnt_q, btick_cnt_d;
    logic [2:0]      bitnum_q, bitnum_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    uart_baudgen #(
        .BDDIVIDER (BDDIVIDER)
    ) u_baudgen (
        .CLK_I  (CLK_I),
        .RST_NI (RST_NI),
        .TICK_O (baudtick)
    );

    // Synchronizer resets high so a released reset never looks like a start edge.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= RX_I;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q     <= st_idle;
            btick_cnt_q <= '0;
            bitnum_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            btick_cnt_q <= btick_cnt_d;
            bitnum_q    <= bitnum_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        btick_cnt_d = btick_cnt_q;
        bitnum_d    = bitnum_q;
        shift_d     = shift_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            st_idle: begin
                // Falling edge only: a line already low must rise first.
                if (rx_q && !rx_s) begin
                    state_d     = st_start;
                    btick_cnt_d = '0;
                end
            end

            st_start: begin
                if (baudtick) begin
                    if (btick_cnt_q == BW'(OVERSAMPLING / 2 - 1)) begin
                        if (!rx_s) begin
                            state_d     = st_data;
                            btick_cnt_d = '0;
                            bitnum_d    = '0;
                        end else begin
                            state_d = st_idle;
                        end
                    end else begin
                        btick_cnt_d = btick_cnt_q + 1'b1;
                    end
                end
            end

            st_data: begin
                if (baudtick) begin
                    if (btick_cnt_q == BW'(OVERSAMPLING - 1)) begin
                        shift_d     = {rx_s, shift_q[7:1]};
                        btick_cnt_d = '0;
                        if (bitnum_q == 3'(DATA_BITS - 1)) begin
                            state_d = st_stop;
                        end else begin
                            bitnum_d = bitnum_q + 1'b1;
                        end
                    end else begin
                        btick_cnt_d = btick_cnt_q + 1'b1;
                    end
                end
            end

            st_stop: begin
                if (baudtick) begin
                    if (btick_cnt_q == BW'(OVERSAMPLING - 1)) begin
                        // Back to idle at mid stop bit so an immediate next start is caught.
                        state_d     = st_idle;
                        btick_cnt_d = '0;
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                        end
                    end else begin
                        btick_cnt_d = btick_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = st_idle;
        endcase
    end

    assign RX_DONE_O = done_q;
    assign RX_DATA_O = data_q;
    assign RX_ERR_O  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int unsigned OVS = 16;
    localparam int unsigned BDD = 3;
    localparam int unsigned BIT = OVS * BDD;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       done;
    logic [7:0] data;
    logic       err;

    uart_rx #(
        .OVERSAMPLING (OVS),
        .BDDIVIDER    (BDD)
    ) dut (
        .CLK_I     (clk),
        .RST_NI    (rst_n),
        .RX_I      (rx),
        .RX_DONE_O (done),
        .RX_DATA_O (data),
        .RX_ERR_O  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] dat;
        longint     cyc;
    } ev_t;

    ev_t    ev_q[$];
    ev_t    exp_q[$];
    longint cyc;
    int     both_cnt;
    int     checks;
    int     errors;
    logic [7:0] last_good;
    longint t_start;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe pulses away from the active edge; a stretched pulse logs twice.
    always @(negedge clk) begin
        if (done && err) both_cnt <= both_cnt + 1;
        if (done) ev_q.push_back('{1'b0, data, cyc});
        if (err)  ev_q.push_back('{1'b1, data, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Ideal 8N1 transmitter: start, 8 data bits LSB first, one stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        @(negedge clk);
        rx      = 1'b0;
        t_start = cyc;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BIT);
        end
        rx = stop_v;
        wait_cycles(BIT);
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic stop_v);
        if (stop_v) begin
            exp_q.push_back('{1'b0, b, 0});
            last_good = b;
        end else begin
            exp_q.push_back('{1'b1, last_good, 0});
        end
    endtask

    task automatic compare_events(input string tag);
        int unsigned n;
        chk({tag, "_count"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            chk($sformatf("%s_kind%0d", tag, i), 32'(ev_q[i].is_err), 32'(exp_q[i].is_err));
            chk($sformatf("%s_data%0d", tag, i), 32'(ev_q[i].dat), 32'(exp_q[i].dat));
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        longint lat;
        logic [7:0] b;
        logic       s;
        int unsigned gap;

        checks    = 0;
        errors    = 0;
        both_cnt  = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        wait_cycles(5);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_err",  32'(err),  32'h0);
        rst_n = 1'b1;
        wait_cycles(2 * BIT);

        // 1: single frame, latency about 9.5 bit periods
        send_frame(8'hA5, 1'b1);
        expect_frame(8'hA5, 1'b1);
        rx = 1'b1;
        wait_cycles(BIT);
        if (ev_q.size() > 0) lat = ev_q[0].cyc - t_start;
        else                 lat = 0;
        chk("latency_window",
            32'((lat >= longint'(BIT * 19 / 2 - 2 * BDD - 6)) &&
                (lat <= longint'(BIT * 19 / 2 + 2 * BDD + 6))), 32'h1);
        compare_events("t1_a5");
        chk("t1_held", 32'(data), 32'hA5);

        // 2: short low glitch is rejected, next frame received
        @(negedge clk);
        rx = 1'b0;
        wait_cycles(BIT / 4);
        rx = 1'b1;
        wait_cycles(2 * BIT);
        compare_events("t2_glitch");
        send_frame(8'h3C, 1'b1);
        expect_frame(8'h3C, 1'b1);
        rx = 1'b1;
        wait_cycles(BIT);
        compare_events("t2_3c");

        // 3: framing error, line stays low, no retrigger until it rises
        send_frame(8'h3C, 1'b0);
        expect_frame(8'h3C, 1'b0);
        wait_cycles(2 * BIT);
        rx = 1'b1;
        wait_cycles(2 * BIT);
        compare_events("t3_ferr");
        chk("t3_data_kept", 32'(data), 32'h3C);
        send_frame(8'h96, 1'b1);
        expect_frame(8'h96, 1'b1);
        rx = 1'b1;
        wait_cycles(BIT);
        compare_events("t3_after");

        // 4: back-to-back frames, zero idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        expect_frame(8'h00, 1'b1);
        expect_frame(8'hFF, 1'b1);
        expect_frame(8'h55, 1'b1);
        rx = 1'b1;
        wait_cycles(BIT);
        compare_events("t4_b2b");

        // 5: reset mid-byte aborts the frame
        @(negedge clk);
        rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_cycles(BIT);
        end
        rx = 1'b1;
        wait_cycles(BIT / 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", 32'(data), 32'h0);
        chk("t5_rst_done", 32'(done), 32'h0);
        chk("t5_rst_err",  32'(err),  32'h0);
        wait_cycles(50);
        rst_n     = 1'b1;
        last_good = 8'h00;
        wait_cycles(2 * BIT);
        compare_events("t5_abort");
        send_frame(8'h81, 1'b1);
        expect_frame(8'h81, 1'b1);
        rx = 1'b1;
        wait_cycles(BIT);
        compare_events("t5_81");
        chk("t5_data", 32'(data), 32'h81);

        // 6: random byte stream with occasional framing errors and random gaps
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            send_frame(b, s);
            expect_frame(b, s);
            gap = s ? $urandom_range(0, BIT) : $urandom_range(BIT / 2, BIT);
            if (gap > 0) begin
                rx = 1'b1;
                wait_cycles(gap);
            end
        end
        rx = 1'b1;
        wait_cycles(2 * BIT);
        compare_events("t6_rand");
        chk("t6_data_final", 32'(data), 32'(last_good));

        chk("never_both", 32'(both_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Receive half of the debug-link UART. Oversamples the asynchronous serial line, detects and validates the start bit, and samples eight data bits LSB-first at mid-bit. Checks the stop bit, then presents the received byte with a one-cycle done strobe, or a framing-error strobe. Sits beside the transmitter in the UART interface and feeds received bytes to the debug-module frontend.

Parameters:
OVERSAMPLING, 16, baud ticks per bit period; even, >= 4
BDDIVIDER, 27, CLK_I cycles per baud tick (bit period = OVERSAMPLING*BDDIVIDER cycles)

Ports:
CLK_I  in  1  system clock, rising edge
RST_NI  in  1  reset; asynchronous, active-low
RX_I  in  1  serial line, asynchronous to CLK_I, idle high
RX_DONE_O  out  1  one-cycle pulse: valid byte on RX_DATA_O
RX_DATA_O  out  8  last correctly received byte; held until next valid frame
RX_ERR_O  out  1  one-cycle pulse: stop bit sampled low (framing error)

Behaviour:
- Reset (async assert, sync release):
  - state=st_idle; all counters and shift register 0; synchronizer flops 1.
  - RX_DONE_O=0, RX_DATA_O=8'h00, RX_ERR_O=0.
- Input conditioning:
  - RX_I passes through a 2-flop synchronizer, then a third flop (rx_q) for edge detection.
  - All FSM decisions use the synchronized value rx_s.
- Baud tick generator:
  - Free-running counter 0..BDDIVIDER-1.
  - One-cycle baudtick when the counter wraps.
  - Not resynchronized to the start edge; phase error is at most 1 tick (1/OVERSAMPLING bit).
- Start detection (st_idle):
  - On a falling edge (rx_q=1, rx_s=0): go to st_start, btick_cnt=0.
  - A line that is already low (stuck low, or following an error) does not retrigger; a high level must be seen first.
- st_start:
  - Count baudticks.
  - At the tick where btick_cnt==OVERSAMPLING/2-1 (mid start bit):
    - rx_s=0: go to st_data, btick_cnt=0, bitnum=0.
    - rx_s=1: glitch; return to st_idle with no output activity.
- st_data:
  - Count baudticks. At the tick where btick_cnt==OVERSAMPLING-1:
    - Sample rx_s: shift = {rx_s, shift[7:1]} (LSB first).
    - btick_cnt=0.
    - If bitnum==7, go to st_stop; else bitnum+1.
  - Otherwise btick_cnt+1 on each tick.
- st_stop:
  - At the tick where btick_cnt==OVERSAMPLING-1, sample rx_s:
    - 1: RX_DATA_O<=shift and RX_DONE_O=1 for exactly one cycle (registered, the cycle after the sampling tick).
    - 0: RX_ERR_O=1 for one cycle; RX_DATA_O unchanged.
  - Either way, return to st_idle.
- Latency: done/err asserts about 9.5 bit periods (+3 sync cycles, +≤1 tick jitter) after the RX_I falling edge.
- Back-to-back frames:
  - Receiver is idle again at mid stop bit, so a start edge immediately following the stop bit is caught.
  - No minimum idle time is required beyond the half stop bit.
- RX_DONE_O and RX_ERR_O are never asserted in the same cycle.
- No backpressure: consumer must take RX_DATA_O before the next done pulse, at least 9 bit periods later.
- Reset mid-frame: immediate abort; no done/err pulse; the next frame is received normally after release.
- btick_cnt width: $clog2(OVERSAMPLING). bitnum: 3 bits. No overflow is possible within the legal ranges.

Decomposition:
- uart_pkg:
  - rx_state_t enum (st_idle, st_start, st_data, st_stop), 2-bit logic.
  - Frame constants DATA_BITS=8, STOP_BITS=1.
  - Shared by uart_rx and the transmitter.
- Sub-module uart_baudgen (params BDDIVIDER; ports CLK_I, RST_NI, TICK_O):
  - One instance here.
  - The transmitter migrates to the same module.

Test Plan (BDDIVIDER=27, OVERSAMPLING=16, bit=432 cycles):
1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one RX_DONE_O pulse ≈4104±30 cycles after start edge; RX_DATA_O=8'hA5; RX_ERR_O never high.
2. Low glitch of 100 cycles on an idle line -> FSM returns to st_idle; no done or err pulse; next frame 0x3C received correctly.
3. Frame 0x3C with stop bit driven 0, line held low 2 bit times, then high -> exactly one RX_ERR_O pulse; RX_DATA_O keeps prior value; no spurious start until the line rises and falls again.
4. Back-to-back 0x00, 0xFF, 0x55 with zero idle gap -> three done pulses, data in order, no errors.
5. Assert RST_NI low mid-byte (after bit 3), release 50 cycles later, then send 0x81 -> outputs reset to 0 immediately; no pulse for the aborted frame; RX_DATA_O=8'h81 after the next frame.
6. Loopback against uart_tx driving 256 sequential bytes -> every byte matches; zero errors.
